// File: rtl/key_select_queue.sv
// Key-event selector: maps programmable scan codes to IDs, drops typematic repeats,
// and queues confirmed selections behind a valid/ready output port.
module key_select_queue #(
    parameter int                    NUM_KEYS         = 12,
    parameter logic [NUM_KEYS*9-1:0] KEY_TABLE        = {9'h03A, 9'h032, 9'h031, 9'h02A,
                                                         9'h03B, 9'h033, 9'h034, 9'h02B,
                                                         9'h03C, 9'h035, 9'h02C, 9'h02D},
    parameter logic [8:0]            CONFIRM_CODE     = 9'h05A,
    parameter logic [8:0]            CANCEL_CODE      = 9'h066,
    parameter int                    FIFO_DEPTH       = 4,
    parameter bit                    CLEAR_ON_CONFIRM = 1'b0,
    localparam int                   IDW              = $clog2(NUM_KEYS + 1),
    localparam int                   CW               = $clog2(FIFO_DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ev_valid,
    input  logic [8:0]     ev_code,
    input  logic           ev_make,
    output logic [IDW-1:0] sel_id,
    output logic           sel_change,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    input  logic           out_ready,
    output logic           overflow,
    output logic [CW-1:0]  count
);

    // Output handshake: the head entry on out_id transfers on any rising clk edge
    // where out_valid and out_ready are both 1; out_valid never depends on out_ready.

    localparam int             PW       = $clog2(FIFO_DEPTH);
    localparam int             HW       = NUM_KEYS + 2;
    localparam int             CONF_BIT = NUM_KEYS;
    localparam int             CANC_BIT = NUM_KEYS + 1;
    localparam logic [IDW-1:0] NONE     = IDW'(NUM_KEYS);
    localparam logic [CW-1:0]  FULL     = CW'(FIFO_DEPTH);

    logic [IDW-1:0] sel_q, sel_d;
    logic           sel_change_q, sel_change_d;
    logic           overflow_q, overflow_d;
    logic [HW-1:0]  held_q, held_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IDW-1:0] mem_q [FIFO_DEPTH];

    logic           hit;
    logic [IDW-1:0] hit_idx;
    logic           is_conf;
    logic           is_canc;
    logic [HW-1:0]  key_mask;
    logic           act_make;
    logic           push_req;
    logic           push_acc;
    logic           pop;

    // Table lookup; scanning downwards leaves the lowest matching index.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        key_mask = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (ev_code == KEY_TABLE[i*9 +: 9]) begin
                hit         = 1'b1;
                hit_idx     = IDW'(i);
                key_mask    = '0;
                key_mask[i] = 1'b1;
            end
        end
        is_conf = !hit && (ev_code == CONFIRM_CODE);
        is_canc = !hit && !is_conf && (ev_code == CANCEL_CODE);
        if (is_conf) key_mask[CONF_BIT] = 1'b1;
        if (is_canc) key_mask[CANC_BIT] = 1'b1;
    end

    // Unmapped codes leave key_mask empty, so they are never filtered.
    assign act_make = ev_valid && ev_make && ((held_q & key_mask) == '0);
    assign pop      = (count_q != '0) && out_ready;
    assign push_req = act_make && is_conf && (sel_q != NONE);
    assign push_acc = push_req && ((count_q != FULL) || pop);

    always_comb begin
        held_d = held_q;
        if (ev_valid) begin
            if (ev_make) held_d = held_q | key_mask;
            else         held_d = held_q & ~key_mask;
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (act_make) begin
            if (hit) begin
                sel_d = hit_idx;
            end else if (is_conf) begin
                if (CLEAR_ON_CONFIRM && push_acc) sel_d = NONE;
            end else begin
                sel_d = NONE;
            end
        end
        sel_change_d = (sel_d != sel_q);
        overflow_d   = push_req && !push_acc;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q        <= NONE;
            sel_change_q <= 1'b0;
            overflow_q   <= 1'b0;
            held_q       <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            sel_q        <= sel_d;
            sel_change_q <= sel_change_d;
            overflow_q   <= overflow_d;
            held_q       <= held_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage is not reset; out_id is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= sel_q;
    end

    assign sel_id     = sel_q;
    assign sel_change = sel_change_q;
    assign overflow   = overflow_q;
    assign count      = count_q;
    assign out_valid  = (count_q != '0);
    assign out_id     = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule
